// File: rtl/photon_gate_counter.sv
`default_nettype none
// ============================================================================
// Module      : photon_gate_counter
// Description : Counts photon detector pulses over back-to-back gate windows
//               of GATE_CYCLES clocks. The count of each completed window is
//               latched as a snapshot and served to an SPI slave as a 5-byte
//               frame. Byte 0 is status ({valid, ovf, 2'b00, seq[3:0]}).
//               Bytes 1..4 are the 32-bit zero-extended count, MSB first.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W        accumulator / snapshot width (8..32)
//   GATE_CYCLES  window length in clk cycles (>= 4)
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   PHOTON       asynchronous detector pulse (>= 2 clk high, >= 2 clk low)
//   enable       level; high runs gate windows back to back
//   tx_start     1-cycle pulse at SPI message start; latches frame, index 0
//   tx_next      1-cycle pulse when the current byte was consumed
//   tx_byte      byte currently offered for transmit (registered)
//   count_valid  an unread snapshot is held (cleared by tx_start)
//   overflow     the held snapshot saturated
//   gate_active  a window is in progress (registered)
// ============================================================================
module photon_gate_counter #(
  parameter int CNT_W       = 32,
  parameter int GATE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PHOTON,
  input  logic       enable,
  input  logic       tx_start,
  input  logic       tx_next,
  output logic [7:0] tx_byte,
  output logic       count_valid,
  output logic       overflow,
  output logic       gate_active
);

  localparam int                 TIMER_W      = $clog2(GATE_CYCLES);
  localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_ACC_MAX    = '1;
  localparam logic [2:0]         C_IDX_DONE   = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  // --------------------------------------------------------------------------
  // Input conditioning. Three synchronizer stages, then the rising-edge
  // detect is registered so an edge is counted on the 4th clk edge after
  // PHOTON rises.
  // --------------------------------------------------------------------------
  logic [2:0] sync_q;
  logic       edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], PHOTON};
      edge_q <= (sync_q[2:1] == 2'b01);
    end
  end

  // --------------------------------------------------------------------------
  // Window state
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   acc_q,   acc_d;
  logic               sat_q,   sat_d;
  logic [CNT_W-1:0]   snap_q,  snap_d;
  logic               ovf_q,   ovf_d;
  logic [3:0]         seq_q,   seq_d;
  logic               valid_q, valid_d;
  logic               gate_q;

  // Accumulator value including this cycle's edge, saturating at max. An edge
  // that arrives while already at max marks the window as saturated.
  logic [CNT_W-1:0] acc_inc;
  logic             sat_next;
  logic             acc_at_max;

  always_comb begin
    acc_at_max = (acc_q == C_ACC_MAX);
    acc_inc    = acc_q;
    sat_next   = sat_q;
    if (edge_q) begin
      if (acc_at_max) begin
        sat_next = 1'b1;
      end else begin
        acc_inc = acc_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q;
    seq_d   = seq_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        acc_d   = '0;
        sat_d   = 1'b0;
        if (enable) begin
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!enable) begin
          // Abort: the partial window is thrown away without a snapshot.
          state_d = S_IDLE;
          timer_d = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else if (timer_q == C_TIMER_LAST) begin
          // Closing cycle: an edge on this very cycle belongs to this window.
          snap_d  = acc_inc;
          ovf_d   = sat_next;
          seq_d   = seq_q + 4'd1;
          timer_d = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          acc_d   = acc_inc;
          sat_d   = sat_next;
        end
      end
    endcase

    // Read-and-clear; a window closing on the same cycle re-sets the flag.
    if (tx_start) begin
      valid_d = 1'b0;
    end
    if ((state_q == S_COUNT) && enable && (timer_q == C_TIMER_LAST)) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
      seq_q   <= 4'd0;
      valid_q <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
      gate_q  <= (state_q == S_COUNT);
    end
  end

  // --------------------------------------------------------------------------
  // Readout. The frame buffer is loaded only on tx_start, so snapshots taken
  // during a readout never disturb the frame in flight.
  // --------------------------------------------------------------------------
  logic [31:0] snap_ext;
  logic [39:0] frame_q, frame_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  tx_byte_q, tx_byte_d;

  always_comb begin
    snap_ext              = '0;
    snap_ext[CNT_W-1:0]   = snap_q;
  end

  always_comb begin
    frame_d = frame_q;
    idx_d   = idx_q;
    if (tx_start) begin
      frame_d = {valid_q, ovf_q, 2'b00, seq_q, snap_ext};
      idx_d   = 3'd0;
    end else if (tx_next && (idx_q != C_IDX_DONE)) begin
      idx_d = idx_q + 3'd1;
    end

    // tx_byte is registered from the next frame/index so it follows the
    // tx_start / tx_next pulse by exactly one clk.
    case (idx_d)
      3'd0:    tx_byte_d = frame_d[39:32];
      3'd1:    tx_byte_d = frame_d[31:24];
      3'd2:    tx_byte_d = frame_d[23:16];
      3'd3:    tx_byte_d = frame_d[15:8];
      3'd4:    tx_byte_d = frame_d[7:0];
      default: tx_byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      idx_q     <= C_IDX_DONE;
      tx_byte_q <= 8'h00;
    end else begin
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign tx_byte     = tx_byte_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;
  assign gate_active = gate_q;

endmodule
`default_nettype wire
